cypher_feeder: RTL
==================

// Module: cypher_feeder
// PURPOSE
//  Requester side of the cypher/compare handshake: gathers a key nibble and a cypher nibble stream,
//  presents cypher/compared to the nibble-match engine with a one-cycle read strobe, waits for its
//  match (done) flag, captures its sum and returns it through a valid/ack result port.
//  Sits between the host nibble stream and the match engine's cypher/compared/read/match/sum pins.
// PARAMETERS
//  NIBBLES   4    cypher nibbles per frame; cypher width CW = 4*NIBBLES (16 at default)
//  SUM_W     8    width of engine sum and res_sum
//  TIMEOUT   64   max cycles waited for match after read; must be >= 2
// PORTS
//  clock       in   1      single clock, all logic rising-edge
//  reset       in   1      synchronous, active-high
//  in_data     in   4      frame nibble: first = compare key, then cypher nibbles MSN first
//  in_valid    in   1      in_data valid
//  in_ready    out  1      feeder accepts nibble (transfer = in_valid & in_ready)
//  cypher      out  CW     cypher word to engine
//  compared    out  4      key nibble to engine
//  read        out  1      one-cycle start strobe to engine
//  match       in   1      engine done flag; sum valid while high
//  sum         in   SUM_W  engine result
//  res_valid   out  1      result held for host
//  res_sum     out  SUM_W  captured sum (0 on timeout)
//  res_timeout out  1      1 = engine did not answer within TIMEOUT
//  res_ack     in   1      host consumes result (transfer = res_valid & res_ack)
//  busy        out  1      high in every state except LOAD
// BEHAVIOUR
//  Reset: state=LOAD, nibble count=0, cypher=0, compared=0, read=0, res_valid=0, res_sum=0,
//   res_timeout=0, wait counter=0. Reset in any state aborts the frame; partial nibbles discarded.
//  FSM: LOAD -> ISSUE -> WAIT -> RESULT -> LOAD.
//  LOAD: in_ready=1. Count k=0..NIBBLES. k=0 transfer -> compared<=in_data. k>=1 transfer ->
//   cypher <= {cypher[CW-5:0], in_data} (first cypher nibble ends in cypher[CW-1:CW-4]).
//   On transfer with k==NIBBLES go to ISSUE next cycle; count clears. in_valid=0 cycles: hold.
//  ISSUE: exactly one cycle; read=1, in_ready=0. Wait counter cleared. Next state WAIT.
//  WAIT: read=0. cypher/compared hold stable from ISSUE until leaving WAIT. match sampled
//   each WAIT cycle (first WAIT cycle is the cycle after read; match during ISSUE ignored).
//   match=1 -> res_sum<=sum, res_timeout<=0, go RESULT. Else counter++; counter reaching
//   TIMEOUT-1 with match=0 -> res_sum<=0, res_timeout<=1, go RESULT. Match on last cycle wins.
//  RESULT: res_valid=1, res_sum/res_timeout stable, in_ready=0. res_ack=1 -> res_valid=0 and
//   state LOAD next cycle; res_ack=0 -> hold indefinitely. res_ack outside RESULT ignored.
//  Latency: last nibble transfer at cycle t -> read=1 at t+1; match first seen at t+2+d ->
//   res_valid=1 at t+3+d. Back-to-back frames: next nibble accepted the cycle after ack.
//  cypher/compared keep last values in LOAD until overwritten (engine ignores them without read).
// TESTING
//  1 frame A,1,A,3,A (no gaps); engine raises match at 5th WAIT cycle with sum=8'd2 ->
//    cypher=16'h1A3A, compared=4'hA, read high exactly 1 cycle, res_valid with res_sum=2, timeout=0.
//  2 same frame, engine never answers -> res_valid exactly TIMEOUT(64) cycles after read,
//    res_sum=0, res_timeout=1.
//  3 in_valid toggled 1,0,0,1,... across frame 5,F,0,5,5 -> cypher=16'hF055, compared=4'h5,
//    no read before the fifth transfer; in_ready stays 1 during gaps.
//  4 res_ack held 0 for 20 cycles after result -> res_valid/res_sum stable, in_ready=0, busy=1;
//    ack pulse -> res_valid=0 next cycle, in_ready=1.
//  5 reset asserted mid-LOAD (2 nibbles in) and mid-WAIT -> all outputs at reset values next
//    cycle; subsequent full frame 3,1,2,3,4 gives cypher=16'h1234 with no leftover nibbles.
//  6 match held high during ISSUE and onward, sum=8'd7 -> ISSUE match ignored, captured in first
//    WAIT cycle, res_sum=7.

Source files
------------

// File: rtl/cypher_feeder.sv
// Requester for the nibble-match engine: collects a key nibble plus a cypher nibble stream,
// strobes the engine, waits (bounded) for its match flag and hands the sum back to the host.
module cypher_feeder #(
  parameter int NIBBLES = 4,
  parameter int SUM_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*NIBBLES-1:0]   cypher,
  output logic [3:0]             compared,
  output logic                   read,
  input  logic                   match,
  input  logic [SUM_W-1:0]       sum,
  output logic                   res_valid,
  output logic [SUM_W-1:0]       res_sum,
  output logic                   res_timeout,
  input  logic                   res_ack,
  output logic                   busy
);

  localparam int CW = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, RESULT} state_t;

  state_t           state_reg;
  logic [KW-1:0]    nib_cnt_reg;
  logic [TW-1:0]    wait_cnt_reg;
  logic [CW-1:0]    cypher_reg;
  logic [CW-1:0]    cypher_next;
  logic [3:0]       compared_reg;
  logic             read_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             res_valid_reg;
  logic [SUM_W-1:0] res_sum_reg;
  logic             res_timeout_reg;

  // A single-nibble cypher has nothing to shift out; avoid a negative slice in that case.
  generate
    if (NIBBLES > 1) begin : g_shift
      assign cypher_next = {cypher_reg[CW-5:0], in_data};
    end else begin : g_noshift
      assign cypher_next = in_data;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= LOAD;
      nib_cnt_reg     <= '0;
      wait_cnt_reg    <= '0;
      cypher_reg      <= '0;
      compared_reg    <= '0;
      read_reg        <= 1'b0;
      in_ready_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_sum_reg     <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (in_valid) begin
            if (nib_cnt_reg == '0) compared_reg <= in_data;
            else                   cypher_reg   <= cypher_next;
            if (nib_cnt_reg == KW'(NIBBLES)) begin
              nib_cnt_reg  <= '0;
              state_reg    <= ISSUE;
              read_reg     <= 1'b1;
              in_ready_reg <= 1'b0;
              busy_reg     <= 1'b1;
            end else begin
              nib_cnt_reg <= nib_cnt_reg + 1'b1;
            end
          end
        end
        ISSUE: begin
          read_reg     <= 1'b0;
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          // A match on the final allowed cycle takes priority over the timeout.
          if (match) begin
            res_sum_reg     <= sum;
            res_timeout_reg <= 1'b0;
            res_valid_reg   <= 1'b1;
            state_reg       <= RESULT;
          end else if (wait_cnt_reg == TW'(TIMEOUT - 2)) begin
            res_sum_reg     <= '0;
            res_timeout_reg <= 1'b1;
            res_valid_reg   <= 1'b1;
            state_reg       <= RESULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RESULT: begin
          if (res_ack) begin
            res_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign cypher      = cypher_reg;
  assign compared    = compared_reg;
  assign read        = read_reg;
  assign res_valid   = res_valid_reg;
  assign res_sum     = res_sum_reg;
  assign res_timeout = res_timeout_reg;
  assign busy        = busy_reg;

endmodule
